// File: rtl/record_timer_ctrl.sv
// Round sequencer for the record screen: drives the elapsed-time counter,
// keeps a lockstep BCD shadow of its count and holds the best finishing time.
module record_timer_ctrl #(
  parameter logic [7:0] LIMIT = 8'h59
) (
  input  logic       clk26,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       goal,
  input  logic       btn_clear_best,
  output logic       timer_start,
  output logic       timer_reset,
  output logic [3:0] cur_bcd1,
  output logic [3:0] cur_bcd0,
  output logic [3:0] best_bcd1,
  output logic [3:0] best_bcd0,
  output logic       best_valid,
  output logic       new_record,
  output logic       timeout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] best_q, best_d;
  logic       best_valid_q, best_valid_d;
  logic       new_record_q, new_record_d;
  logic       timeout_q, timeout_d;
  logic       timer_start_q, timer_start_d;
  logic       timer_reset_q, timer_reset_d;

  // Tens never exceeds 8 while LIMIT is legal, so no tens wrap is needed.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  // Packed two-digit BCD orders the same as its binary value (tens first).
  function automatic logic bcd_less(input logic [7:0] a, input logic [7:0] b);
    return (a < b);
  endfunction

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    new_record_d = new_record_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (btn_start) begin
          state_d      = S_RUN;
          cur_d        = 8'h00;
          timeout_d    = 1'b0;
          new_record_d = 1'b0;
        end
        if (btn_clear_best) begin
          best_d       = 8'h00;
          best_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (btn_stop) begin
          state_d = S_IDLE;
          cur_d   = 8'h00;
        end else if (goal) begin
          state_d = S_DONE;
          if (!best_valid_q || bcd_less(cur_q, best_q)) begin
            best_d       = cur_q;
            best_valid_d = 1'b1;
            new_record_d = 1'b1;
          end
        end else if (cur_q == LIMIT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cur_d = bcd_inc(cur_q);
        end
      end
      S_DONE: begin
        if (btn_stop) begin
          state_d      = S_IDLE;
          new_record_d = 1'b0;
          timeout_d    = 1'b0;
        end else if (btn_start) begin
          state_d      = S_RUN;
          cur_d        = 8'h00;
          new_record_d = 1'b0;
          timeout_d    = 1'b0;
        end else if (btn_clear_best) begin
          best_d       = 8'h00;
          best_valid_d = 1'b0;
          new_record_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counter controls follow the next state so they are registered with it.
    timer_start_d = (state_d == S_RUN);
    timer_reset_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk26) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_q         <= 8'h00;
      best_q        <= 8'h00;
      best_valid_q  <= 1'b0;
      new_record_q  <= 1'b0;
      timeout_q     <= 1'b0;
      timer_start_q <= 1'b0;
      timer_reset_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      best_q        <= best_d;
      best_valid_q  <= best_valid_d;
      new_record_q  <= new_record_d;
      timeout_q     <= timeout_d;
      timer_start_q <= timer_start_d;
      timer_reset_q <= timer_reset_d;
    end
  end

  assign timer_start = timer_start_q;
  assign timer_reset = timer_reset_q;
  assign cur_bcd1    = cur_q[7:4];
  assign cur_bcd0    = cur_q[3:0];
  assign best_bcd1   = best_q[7:4];
  assign best_bcd0   = best_q[3:0];
  assign best_valid  = best_valid_q;
  assign new_record  = new_record_q;
  assign timeout     = timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_record_timer_ctrl.sv
// Directed bench for record_timer_ctrl: scripted rounds with hand-computed
// expected counts, records, timeouts and reset behaviour.
module tb_record_timer_ctrl;

  logic       clk26 = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       goal = 1'b0;
  logic       btn_clear_best = 1'b0;
  logic       timer_start, timer_reset;
  logic [3:0] cur_bcd1, cur_bcd0, best_bcd1, best_bcd0;
  logic       best_valid, new_record, timeout;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  record_timer_ctrl #(.LIMIT(8'h59)) dut (
    .clk26(clk26), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
    .goal(goal), .btn_clear_best(btn_clear_best),
    .timer_start(timer_start), .timer_reset(timer_reset),
    .cur_bcd1(cur_bcd1), .cur_bcd0(cur_bcd0),
    .best_bcd1(best_bcd1), .best_bcd0(best_bcd0),
    .best_valid(best_valid), .new_record(new_record), .timeout(timeout),
    .state(state)
  );

  always #5 clk26 = ~clk26;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk26);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    btn_start = 1'b1; tick(); btn_start = 1'b0;
  endtask

  task automatic pulse_goal();
    goal = 1'b1; tick(); goal = 1'b0;
  endtask

  task automatic pulse_stop();
    btn_stop = 1'b1; tick(); btn_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    btn_clear_best = 1'b1; tick(); btn_clear_best = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"}, state, 2'd0);
    chk({tag, ".tstart"}, timer_start, 1'b0);
    chk({tag, ".treset"}, timer_reset, 1'b1);
    chk({tag, ".cur"}, {cur_bcd1, cur_bcd0}, 8'h00);
    chk({tag, ".best"}, {best_bcd1, best_bcd0}, 8'h00);
    chk({tag, ".bvalid"}, best_valid, 1'b0);
    chk({tag, ".newrec"}, new_record, 1'b0);
    chk({tag, ".timeout"}, timeout, 1'b0);
  endtask

  // Start a round, count to t, finish with goal and check the outcome.
  task automatic goal_round(input string tag, input logic [7:0] t,
                            input logic [7:0] exp_best, input logic exp_nr);
    pulse_start();
    chk({tag, ".cur0"}, {cur_bcd1, cur_bcd0}, 8'h00);
    ticks(int'(t[7:4]) * 10 + int'(t[3:0]));
    chk({tag, ".curT"}, {cur_bcd1, cur_bcd0}, t);
    pulse_goal();
    chk({tag, ".state"}, state, 2'd2);
    chk({tag, ".curG"}, {cur_bcd1, cur_bcd0}, t);
    chk({tag, ".best"}, {best_bcd1, best_bcd0}, exp_best);
    chk({tag, ".newrec"}, new_record, exp_nr);
    chk({tag, ".tstart"}, timer_start, 1'b0);
  endtask

  initial begin
    ticks(2);
    reset = 1'b0;
    chk_reset_vals("rst");

    // First round establishes a record.
    pulse_start();
    chk("r1.tstart", timer_start, 1'b1);
    chk("r1.treset", timer_reset, 1'b0);
    chk("r1.cur00", {cur_bcd1, cur_bcd0}, 8'h00);
    tick();
    chk("r1.cur01", {cur_bcd1, cur_bcd0}, 8'h01);
    ticks(11);
    chk("r1.cur12", {cur_bcd1, cur_bcd0}, 8'h12);
    pulse_goal();
    chk("r1.state", state, 2'd2);
    chk("r1.cur", {cur_bcd1, cur_bcd0}, 8'h12);
    chk("r1.best", {best_bcd1, best_bcd0}, 8'h12);
    chk("r1.bvalid", best_valid, 1'b1);
    chk("r1.newrec", new_record, 1'b1);
    chk("r1.tstart0", timer_start, 1'b0);

    goal_round("r2", 8'h15, 8'h12, 1'b0);
    goal_round("r3", 8'h12, 8'h12, 1'b0);
    goal_round("r4", 8'h07, 8'h07, 1'b1);

    // Time-limit round with digit carries.
    pulse_start();
    chk("lim.nr_clr", new_record, 1'b0);
    ticks(9);
    chk("lim.c09", {cur_bcd1, cur_bcd0}, 8'h09);
    tick();
    chk("lim.c10", {cur_bcd1, cur_bcd0}, 8'h10);
    ticks(9);
    chk("lim.c19", {cur_bcd1, cur_bcd0}, 8'h19);
    tick();
    chk("lim.c20", {cur_bcd1, cur_bcd0}, 8'h20);
    ticks(39);
    chk("lim.c59", {cur_bcd1, cur_bcd0}, 8'h59);
    chk("lim.run", state, 2'd1);
    chk("lim.to0", timeout, 1'b0);
    tick();
    chk("lim.done", state, 2'd2);
    chk("lim.to1", timeout, 1'b1);
    chk("lim.held", {cur_bcd1, cur_bcd0}, 8'h59);
    chk("lim.best", {best_bcd1, best_bcd0}, 8'h07);
    chk("lim.tstart", timer_start, 1'b0);
    tick();
    chk("lim.held2", {cur_bcd1, cur_bcd0}, 8'h59);

    // Abort at 05, then goal and stop together.
    pulse_start();
    chk("stop.to_clr", timeout, 1'b0);
    ticks(5);
    chk("stop.c05", {cur_bcd1, cur_bcd0}, 8'h05);
    pulse_stop();
    chk("stop.state", state, 2'd0);
    chk("stop.cur", {cur_bcd1, cur_bcd0}, 8'h00);
    chk("stop.treset", timer_reset, 1'b1);
    chk("stop.best", {best_bcd1, best_bcd0}, 8'h07);
    pulse_start();
    ticks(3);
    goal = 1'b1; btn_stop = 1'b1; tick(); goal = 1'b0; btn_stop = 1'b0;
    chk("gs.state", state, 2'd0);
    chk("gs.best", {best_bcd1, best_bcd0}, 8'h07);
    chk("gs.newrec", new_record, 1'b0);

    // Clear ignored in RUN, honoured in DONE.
    pulse_start();
    ticks(2);
    pulse_clear();
    chk("clr.run_bv", best_valid, 1'b1);
    chk("clr.run_best", {best_bcd1, best_bcd0}, 8'h07);
    chk("clr.run_state", state, 2'd1);
    chk("clr.cur03", {cur_bcd1, cur_bcd0}, 8'h03);
    pulse_goal();
    chk("clr.rec03", {best_bcd1, best_bcd0}, 8'h03);
    chk("clr.nr1", new_record, 1'b1);
    pulse_clear();
    chk("clr.bv", best_valid, 1'b0);
    chk("clr.best", {best_bcd1, best_bcd0}, 8'h00);
    chk("clr.nr", new_record, 1'b0);
    chk("clr.state", state, 2'd2);

    // Mid-round reset, then a normal round from 00.
    goal_round("pre", 8'h09, 8'h09, 1'b1);
    pulse_start();
    ticks(30);
    chk("mr.c30", {cur_bcd1, cur_bcd0}, 8'h30);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_reset_vals("mr");
    pulse_start();
    chk("post.cur00", {cur_bcd1, cur_bcd0}, 8'h00);
    chk("post.tstart", timer_start, 1'b1);
    tick();
    chk("post.cur01", {cur_bcd1, cur_bcd0}, 8'h01);
    ticks(3);
    pulse_goal();
    chk("post.best", {best_bcd1, best_bcd0}, 8'h04);
    chk("post.nr", new_record, 1'b1);
    chk("post.bv", best_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
